wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 112 +++++++++++
 tb/tb_wb_regfile.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: 32 x DATA_W register file with a three-stage destination
// pipeline (EX, MEM, WB), RAW hazard stall generation and a WB-stage
// write-through bypass on both read ports.
//
// Ports:
//   clk, rst               single clock, asynchronous active-high reset
//   id_valid, reg_write    decode-stage instruction present / writes a register
//   dst_addr               destination register of the decode instruction
//   rs_addr, rt_addr       read port addresses
//   wb_data                result of the instruction currently in WB
//   rs_data, rt_data       combinational read data (bypassed)
//   stall                  decode must hold this cycle
//   wb_en, wb_addr         WB stage holds a valid register write to wb_addr
module wb_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              reg_write,
  input  logic [4:0]        dst_addr,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              stall,
  output logic              wb_en,
  output logic [4:0]        wb_addr
);

  logic              ex_en_q, ex_en_d;
  logic [4:0]        ex_addr_q, ex_addr_d;
  logic              mem_en_q, mem_en_d;
  logic [4:0]        mem_addr_q, mem_addr_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];

  logic issue;
  logic rs_hz, rt_hz;

  // A pending producer in EX or MEM conflicts with a non-zero source address.
  // WB is deliberately excluded: the bypass already supplies that value.
  function automatic logic hazard(input logic [4:0] a,
                                  input logic ex_en, input logic [4:0] ex_addr,
                                  input logic mem_en, input logic [4:0] mem_addr);
    hazard = (a != 5'd0) &&
             ((ex_en && (ex_addr == a)) || (mem_en && (mem_addr == a)));
  endfunction

  // Read mux: register 0 is hard zero, then the WB bypass, then the array.
  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] a,
                                                  input logic [DATA_W-1:0] stored,
                                                  input logic byp_en,
                                                  input logic [4:0] byp_addr,
                                                  input logic [DATA_W-1:0] byp_data);
    if (a == 5'd0)
      read_port = '0;
    else if (byp_en && (byp_addr == a))
      read_port = byp_data;
    else
      read_port = stored;
  endfunction

  always_comb begin
    rs_hz = hazard(rs_addr, ex_en_q, ex_addr_q, mem_en_q, mem_addr_q);
    rt_hz = hazard(rt_addr, ex_en_q, ex_addr_q, mem_en_q, mem_addr_q);
    stall = id_valid & (rs_hz | rt_hz);
    issue = id_valid & ~stall;

    // Writes to register 0 are dropped here so they never reach WB.
    ex_en_d    = issue & reg_write & (dst_addr != 5'd0);
    ex_addr_d  = dst_addr;
    // MEM and WB advance every cycle; a stall only injects a bubble into EX.
    mem_en_d   = ex_en_q;
    mem_addr_d = ex_addr_q;
    wb_en_d    = mem_en_q;
    wb_addr_d  = mem_addr_q;

    for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
    if (wb_en_q && (wb_addr_q != 5'd0)) regs_d[wb_addr_q] = wb_data;
    regs_d[0] = '0;

    rs_data = read_port(rs_addr, regs_q[rs_addr], wb_en_q, wb_addr_q, wb_data);
    rt_data = read_port(rt_addr, regs_q[rt_addr], wb_en_q, wb_addr_q, wb_data);
    wb_en   = wb_en_q;
    wb_addr = wb_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_en_q    <= 1'b0;
      ex_addr_q  <= 5'd0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= 5'd0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= 5'd0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      ex_en_q    <= ex_en_d;
      ex_addr_q  <= ex_addr_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        reg_write;
  logic [4:0]  dst_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] wb_data;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;

  int n_cmp;
  int n_miss;

  wb_regfile #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .reg_write(reg_write),
    .dst_addr(dst_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .wb_data(wb_data), .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        idv;
    logic        rw;
    logic [4:0]  dst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] wbd;
    logic        e_stall;
    logic        e_wben;
    logic [4:0]  e_wbaddr;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic idv, input logic rw, input logic [4:0] dst,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [31:0] wbd, input logic e_stall,
                              input logic e_wben, input logic [4:0] e_wbaddr,
                              input logic [31:0] e_rs, input logic [31:0] e_rt);
    vec_t v;
    v.idv = idv; v.rw = rw; v.dst = dst; v.rs = rs; v.rt = rt; v.wbd = wbd;
    v.e_stall = e_stall; v.e_wben = e_wben; v.e_wbaddr = e_wbaddr;
    v.e_rs = e_rs; v.e_rt = e_rt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic idv, input logic rw, input logic [4:0] dst,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] wbd);
    id_valid = idv; reg_write = rw; dst_addr = dst;
    rs_addr = rs; rt_addr = rt; wb_data = wbd;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_miss = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    #1 rst = 1'b1;

    // Reset state, before and after a clock edge while held.
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 32'hFFFF_FFFF);
    #2;
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rs_data", rs_data, 32'd0);
    chk("rst_rt_data", rt_data, 32'd0);
    tick();
    chk("rst_hold_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_hold_stall", {31'd0, stall}, 32'd0);
    chk("rst_hold_rs", rs_data, 32'd0);

    //            idv rw dst rs  rt  wbd           stl wen wad  e_rs          e_rt
    // basic write to r5
    tbl.push_back(mk(1, 1, 5,  0,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  5,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  5,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  5,  5,  32'hDEADBEEF, 0, 1, 5,  32'hDEADBEEF, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0,  5,  0,  32'h0,        0, 0, 0,  32'hDEADBEEF, 32'h0));
    // back-to-back RAW on r7 via rs
    tbl.push_back(mk(1, 1, 7,  0,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 0,  7,  0,  32'h0,        1, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 0,  7,  0,  32'h0,        1, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 0,  7,  0,  32'hA5A50007, 0, 1, 7,  32'hA5A50007, 32'h0));
    tbl.push_back(mk(0, 0, 0,  7,  5,  32'h0,        0, 0, 0,  32'hA5A50007, 32'hDEADBEEF));
    // write to r0 is suppressed
    tbl.push_back(mk(1, 1, 0,  0,  0,  32'hFFFFFFFF, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 0,  0,  0,  32'hFFFFFFFF, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  0,  0,  32'hFFFFFFFF, 0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  0,  0,  32'hFFFFFFFF, 0, 0, 0,  32'h0,        32'h0));
    // r3 = 0x33, then a non-writing dst=3 must not stall or write
    tbl.push_back(mk(1, 1, 3,  0,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  0,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  0,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  0,  3,  32'h33,       0, 1, 3,  32'h0,        32'h33));
    tbl.push_back(mk(1, 0, 3,  0,  3,  32'h0,        0, 0, 0,  32'h0,        32'h33));
    tbl.push_back(mk(1, 0, 0,  0,  3,  32'h0,        0, 0, 0,  32'h0,        32'h33));
    tbl.push_back(mk(0, 0, 0,  0,  3,  32'h0,        0, 0, 0,  32'h0,        32'h33));
    tbl.push_back(mk(0, 0, 0,  0,  3,  32'hBAD,      0, 0, 3,  32'h0,        32'h33));
    tbl.push_back(mk(0, 0, 0,  0,  3,  32'h0,        0, 0, 0,  32'h0,        32'h33));
    // dual-port collision on r12 during its WB write
    tbl.push_back(mk(1, 1, 12, 0,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  0,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  0,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0,  12, 12, 32'h12345678, 0, 1, 12, 32'h12345678, 32'h12345678));
    tbl.push_back(mk(0, 0, 0,  12, 12, 32'h0,        0, 0, 0,  32'h12345678, 32'h12345678));
    // RAW on r20 via rt
    tbl.push_back(mk(1, 1, 20, 0,  0,  32'h0,        0, 0, 0,  32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 0,  5,  20, 32'h0,        1, 0, 0,  32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(1, 0, 0,  5,  20, 32'h0,        1, 0, 0,  32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(1, 0, 0,  5,  20, 32'h20202020, 0, 1, 20, 32'hDEADBEEF, 32'h20202020));
    tbl.push_back(mk(0, 0, 0,  0,  20, 32'h0,        0, 0, 0,  32'h0,        32'h20202020));

    // Release reset between edges; the first vector issues at the next edge.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].idv, tbl[i].rw, tbl[i].dst, tbl[i].rs, tbl[i].rt, tbl[i].wbd);
      #2;
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("v%0d_wb_en", i), {31'd0, wb_en}, {31'd0, tbl[i].e_wben});
      chk($sformatf("v%0d_wb_addr", i), {27'd0, wb_addr}, {27'd0, tbl[i].e_wbaddr});
      chk($sformatf("v%0d_rs_data", i), rs_data, tbl[i].e_rs);
      chk($sformatf("v%0d_rt_data", i), rt_data, tbl[i].e_rt);
      tick();
    end

    // Mid-operation async reset: r1..r4 written, r8 in WB, r9 in MEM.
    begin
      logic [4:0] dsts [6];
      dsts[0] = 5'd1; dsts[1] = 5'd2; dsts[2] = 5'd3;
      dsts[3] = 5'd4; dsts[4] = 5'd8; dsts[5] = 5'd9;
      for (int k = 0; k < 6; k++) begin
        drive(1'b1, 1'b1, dsts[k], 5'd0, 5'd0, (k >= 3) ? 32'h11 * (k - 2) : 32'h0);
        tick();
      end
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h44);
      tick();
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h88);
      #1;
      chk("pre_rst_wb_en", {31'd0, wb_en}, 32'd1);
      chk("pre_rst_wb_addr", {27'd0, wb_addr}, 32'd8);
      for (int r = 1; r <= 4; r++) begin
        rs_addr = 5'(r);
        #1;
        chk($sformatf("pre_rst_r%0d", r), rs_data, 32'h11 * r);
      end
      rst = 1'b1;
      #1;
      chk("async_rst_wb_en", {31'd0, wb_en}, 32'd0);
      chk("async_rst_wb_addr", {27'd0, wb_addr}, 32'd0);
      id_valid = 1'b1;
      rs_addr = 5'd9;
      rt_addr = 5'd8;
      #0.5;
      chk("async_rst_stall", {31'd0, stall}, 32'd0);
      for (int r = 1; r <= 4; r++) begin
        rs_addr = 5'(r);
        rt_addr = 5'(r);
        #0.5;
        chk($sformatf("async_rst_rs_r%0d", r), rs_data, 32'd0);
        chk($sformatf("async_rst_rt_r%0d", r), rt_data, 32'd0);
      end
      rst = 1'b0;
      // First issue after reset is taken at the very next edge.
      drive(1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 32'hCAFEF00D);
      tick();
      for (int k = 0; k < 2; k++) begin
        drive(1'b0, 1'b0, 5'd0, 5'd9, 5'd8, 32'hCAFEF00D);
        #1;
        chk($sformatf("post_rst%0d_wb_en", k), {31'd0, wb_en}, 32'd0);
        chk($sformatf("post_rst%0d_r9", k), rs_data, 32'd0);
        chk($sformatf("post_rst%0d_r8", k), rt_data, 32'd0);
        tick();
      end
      drive(1'b0, 1'b0, 5'd0, 5'd9, 5'd6, 32'h00660066);
      #1;
      chk("post_rst_issue_wb_en", {31'd0, wb_en}, 32'd1);
      chk("post_rst_issue_wb_addr", {27'd0, wb_addr}, 32'd6);
      chk("post_rst_r9_unwritten", rs_data, 32'd0);
      chk("post_rst_r6_bypass", rt_data, 32'h00660066);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
